sa_job_driver: RTL
==================

SA_JOB_DRIVER -- requirements
Module: sa_job_driver

Interface
REQ-001 Parameter DWIDTH, 64, element width in bits.
REQ-002 Parameter N, 12, matrix dimension.
REQ-003 Parameter TIMEOUT_CYC, 4096, maximum cycles to wait for sa_cal_finish.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, sole clock, all logic on posedge.
REQ-006 Port rst_n, input, 1, active-low reset, sampled on posedge only.
REQ-007 Port in_valid, input, 1, upstream word valid.
REQ-008 Port in_ready, output, 1, driver accepts the word.
REQ-009 Port in_data, input, DWIDTH, matrix element.
REQ-010 Port cfg_enb, input, 3, {enb_7_12, enb_2_6, enb_1}, sampled with the first accepted word of a job.
REQ-011 Port out_valid, output, 1, result word valid.
REQ-012 Port out_ready, input, 1, downstream accepts.
REQ-013 Port out_data, output, DWIDTH, result element.
REQ-014 Port out_last, output, 1, marks C[N-1][N-1].
REQ-015 Port sa_load_en, output, 1, job request to the array.
REQ-016 Port sa_a_row / sa_b_col, output, [N][N]xDWIDTH, operand matrices.
REQ-017 Port sa_enb_1 / sa_enb_2_6 / sa_enb_7_12, output, 1 each, column enables.
REQ-018 Port sa_c_out, input, [N][N]xDWIDTH, array result.
REQ-019 Port sa_cal_finish, input, 1, array done level.
REQ-020 Port busy, output, 1, high in every state except S_LOAD with load count 0.
REQ-021 Port err_timeout, output, 1, sticky until the next job's first accepted word.

Function
REQ-022 States SHALL be S_LOAD, S_RUN, S_RELEASE and S_DRAIN.
REQ-023 S_LOAD: in_ready=1; accepted word k (0..2N*N-1) SHALL be written as A[k/N][k%N] when k<N*N, otherwise as B[(k-N*N)/N][(k-N*N)%N].
REQ-024 Acceptance of word 2N*N-1 SHALL enter S_RUN, with sa_load_en registered high on the next cycle.
REQ-025 sa_a_row, sa_b_col and sa_enb_* SHALL be driven from registers and held stable from S_RUN entry until S_RELEASE exit.
REQ-026 S_RUN with sa_cal_finish=1: capture sa_c_out into the result buffer that cycle, drive sa_load_en=0 the next cycle, go to S_RELEASE.
REQ-027 S_RUN run counter reaching TIMEOUT_CYC without sa_cal_finish: set err_timeout, drive sa_load_en=0, go to S_RELEASE, and skip the drain.
REQ-028 S_RELEASE SHALL hold sa_load_en=0 for at least one cycle and until sa_cal_finish=0, then go to S_DRAIN, or to S_LOAD after a timeout.
REQ-029 S_DRAIN: present C row-major, index 0..N*N-1, with registered out_valid/out_data; advance only on out_valid&out_ready; out_data stable while stalled.
REQ-030 out_last=1 only with index N*N-1; its handshake SHALL return to S_LOAD with the load counter cleared.
REQ-031 sa_cal_finish outside S_RUN/S_RELEASE SHALL be ignored.
REQ-032 in_valid outside S_LOAD SHALL be ignored (in_ready=0).
REQ-033 The load counter is 9 bits, the drain counter 8 bits, and the run counter clog2(TIMEOUT_CYC+1) bits; no wrap inside a job.

Reset
REQ-034 rst_n=0 SHALL force S_LOAD, all counters to 0, in_ready=0, out_valid=0, out_last=0, out_data=0, sa_load_en=0, sa_enb_*=0, busy=0 and err_timeout=0.
REQ-035 Reset mid-job SHALL abandon the job, with no output word after release; operand and result buffers need no reset.
REQ-036 in_ready SHALL rise on the first cycle after rst_n deasserts.

Structure
REQ-037 The sa_pkg package SHALL hold the default DWIDTH/N constants and the state enum typedef.
REQ-038 sa_job_driver SHALL have no sub-module; SystolicArray is instantiated by the parent, alongside the driver.

Verification
REQ-039 A=identity, B[i][j]=i*12+j as real, cfg_enb=3'b111 -> 144 outputs equal B row-major, out_last on the 144th, sa_load_en high for exactly one job.
REQ-040 cfg_enb=3'b001, same operands -> column 0 equals B column 0, columns 1..11 are zero.
REQ-041 Random out_ready at 30% duty during drain -> identical 144-word sequence, out_data never changes while out_valid&!out_ready.
REQ-042 Array model never raises sa_cal_finish, TIMEOUT_CYC=64 -> err_timeout=1 after 64 run cycles, sa_load_en=0, no out_valid, in_ready back to 1.
REQ-043 Back-to-back jobs, model holding sa_cal_finish=1 for 3 cycles after sa_load_en falls -> sa_load_en stays low at least 1 cycle and until finish drops, second job correct.
REQ-044 rst_n=0 asserted at load word 100 and again mid-drain -> all outputs at reset values next cycle, fresh job correct.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array job driver.
package sa_pkg;

    localparam int DWIDTH_DEF = 64;
    localparam int N_DEF      = 12;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2,
        S_DRAIN   = 2'd3
    } sa_state_e;

endpackage

// File: rtl/sa_job_driver.sv
// Streams A/B operands into registers, runs one systolic-array job, then drains C row-major.
// in_valid/in_ready and out_valid/out_ready: a word moves on a clock edge where both are high.
module sa_job_driver
    import sa_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int N           = N_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [2:0]        cfg_enb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              sa_load_en,
    output logic [DWIDTH-1:0] sa_a_row [N][N],
    output logic [DWIDTH-1:0] sa_b_col [N][N],
    output logic              sa_enb_1,
    output logic              sa_enb_2_6,
    output logic              sa_enb_7_12,
    input  logic [DWIDTH-1:0] sa_c_out [N][N],
    input  logic              sa_cal_finish,
    output logic              busy,
    output logic              err_timeout,
    output sa_state_e         dbg_state
);

    localparam int NN    = N * N;
    localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]       LOAD_LAST  = 9'(2 * NN - 1);
    localparam logic [7:0]       DRAIN_LAST = 8'(NN - 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT  = RUN_W'(TIMEOUT_CYC);

    sa_state_e         r_state;
    logic [8:0]        r_load_cnt;
    logic [7:0]        r_drain_cnt;
    logic [RUN_W-1:0]  r_run_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;
    logic              r_out_last;
    logic              r_load_en;
    logic [2:0]        r_enb;
    logic              r_err;

    // A occupies words 0..NN-1, B occupies NN..2*NN-1, both row-major.
    logic [DWIDTH-1:0] r_opnd [2*NN];
    logic [DWIDTH-1:0] r_res  [NN];

    logic             w_accept;
    logic             w_capture;
    logic [7:0]       w_drain_next;
    logic [RUN_W-1:0] w_run_next;

    assign w_accept     = (r_state == S_LOAD) && r_in_ready && in_valid;
    assign w_capture    = (r_state == S_RUN) && sa_cal_finish;
    assign w_drain_next = r_drain_cnt + 8'd1;
    assign w_run_next   = r_run_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opnd[r_load_cnt] <= in_data;
        end
        if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_res[i*N + j] <= sa_c_out[i][j];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign sa_a_row[gi][gj] = r_opnd[gi*N + gj];
            assign sa_b_col[gi][gj] = r_opnd[NN + gi*N + gj];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
            r_run_cnt   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_load_en   <= 1'b0;
            r_enb       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_load_cnt <= r_load_cnt + 9'd1;
                        if (r_load_cnt == 9'd0) begin
                            r_enb <= cfg_enb;
                            r_err <= 1'b0;
                        end
                        if (r_load_cnt == LOAD_LAST) begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b0;
                            r_load_en  <= 1'b1;
                            r_run_cnt  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_run_cnt <= w_run_next;
                    // A finish seen in the same cycle as the limit still counts as success.
                    if (sa_cal_finish) begin
                        r_load_en <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else if (w_run_next == RUN_LIMIT) begin
                        r_err     <= 1'b1;
                        r_load_en <= 1'b0;
                        r_state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!sa_cal_finish) begin
                        if (r_err) begin
                            r_state    <= S_LOAD;
                            r_load_cnt <= '0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_res[0];
                            r_out_last  <= (DRAIN_LAST == 8'd0);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_drain_cnt == DRAIN_LAST) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= S_LOAD;
                            r_load_cnt  <= '0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_drain_cnt <= w_drain_next;
                            r_out_data  <= r_res[w_drain_next];
                            r_out_last  <= (w_drain_next == DRAIN_LAST);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign sa_load_en  = r_load_en;
    assign sa_enb_1    = r_enb[0];
    assign sa_enb_2_6  = r_enb[1];
    assign sa_enb_7_12 = r_enb[2];
    assign err_timeout = r_err;
    assign busy        = !((r_state == S_LOAD) && (r_load_cnt == 9'd0));
    assign dbg_state   = r_state;

endmodule
